// File: rtl/npc_delay_slot_if.sv
`default_nettype none
// ============================================================================
//  Module      : npc_delay_slot_if
//  Description : Signal bundle between the decode/PC stage and the next-PC
//                generator. The master presents PC and decoded control; the
//                slave (npc_delay_slot) returns next PC, link address and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface npc_delay_slot_if;
  logic [31:0] pc;
  logic [2:0]  br_op;
  logic        cmp_eq;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] rs_val;
  logic        stall;
  logic [31:0] npc;
  logic [31:0] link_addr;
  logic        in_slot;
  logic        slot_violation;
  logic        fault;

  modport master (
    output pc, br_op, cmp_eq, imm16, index26, rs_val, stall,
    input  npc, link_addr, in_slot, slot_violation, fault
  );

  modport slave (
    input  pc, br_op, cmp_eq, imm16, index26, rs_val, stall,
    output npc, link_addr, in_slot, slot_violation, fault
  );
endinterface
`default_nettype wire

// File: rtl/npc_delay_slot.sv
`default_nettype none
// ============================================================================
//  Module      : npc_delay_slot
//  Description : Next-PC generator feeding the PC register. Computes sequential,
//                branch, jump and register-jump targets, drives the link
//                address for JAL and keeps a sticky fetch-fault flag.
//                Build option NPC_DELAY_SLOT_EN: when defined, a taken transfer
//                runs one delay-slot instruction before redirecting to a
//                latched target; when undefined, transfers redirect at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_delay_slot #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int          IM_WORDS   = 4096
) (
  input  wire logic          clk,
  input  wire logic          reset,
  npc_delay_slot_if.slave    bus
);

  localparam logic [2:0]  c_op_beq  = 3'd1;
  localparam logic [2:0]  c_op_bne  = 3'd2;
  localparam logic [2:0]  c_op_j    = 3'd3;
  localparam logic [2:0]  c_op_jal  = 3'd4;
  localparam logic [2:0]  c_op_jr   = 3'd5;
  // Highest legal instruction address (last word of instruction memory).
  localparam logic [31:0] c_im_last = IM_BASE + (32'(IM_WORDS) << 2) - 32'd4;

  logic [31:0] w_p4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_target;
  logic        w_taken;
  logic [31:0] w_npc;
  logic        w_legal;
  logic        r_fault;

  assign w_p4     = bus.pc + 32'd4;
  assign w_br_tgt = w_p4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign w_j_tgt  = {w_p4[31:28], bus.index26, 2'b00};

  // Decode the transfer kind into a target address and a taken flag.
  always_comb begin
    w_target = w_p4;
    w_taken  = 1'b0;
    case (bus.br_op)
      c_op_beq: begin w_target = w_br_tgt; w_taken = bus.cmp_eq;  end
      c_op_bne: begin w_target = w_br_tgt; w_taken = ~bus.cmp_eq; end
      c_op_j,
      c_op_jal: begin w_target = w_j_tgt;  w_taken = 1'b1;        end
      c_op_jr:  begin w_target = bus.rs_val; w_taken = 1'b1;      end
      default:  begin w_target = w_p4;     w_taken = 1'b0;        end
    endcase
  end

`ifdef NPC_DELAY_SLOT_EN
  typedef enum logic [0:0] {
    SEQ  = 1'b0,
    SLOT = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_tgt;

  // Select next PC: reset vector, hold on stall, latched target in the slot.
  always_comb begin
    if (reset)                 w_npc = RESET_ADDR;
    else if (bus.stall)        w_npc = bus.pc;
    else if (r_state == SLOT)  w_npc = r_tgt;
    else                       w_npc = w_p4;
  end

  // Delay-slot sequencer: latch the target on a taken transfer, release it next.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEQ;
      r_tgt   <= '0;
    end else if (!bus.stall) begin
      case (r_state)
        SEQ: begin
          if (w_taken) begin
            r_tgt   <= w_target;
            r_state <= SLOT;
          end
        end
        SLOT:    r_state <= SEQ;
        default: r_state <= SEQ;
      endcase
    end
  end

  // A transfer sitting in a delay slot is dropped; flag it for the bench.
  assign bus.slot_violation = ~reset & ~bus.stall & (r_state == SLOT) & w_taken;
  assign bus.in_slot        = (r_state == SLOT);
  assign bus.link_addr      = bus.pc + 32'd8;
`else
  // Select next PC: reset vector, hold on stall, otherwise redirect immediately.
  always_comb begin
    if (reset)           w_npc = RESET_ADDR;
    else if (bus.stall)  w_npc = bus.pc;
    else if (w_taken)    w_npc = w_target;
    else                 w_npc = w_p4;
  end

  assign bus.slot_violation = 1'b0;
  assign bus.in_slot        = 1'b0;
  assign bus.link_addr      = w_p4;
`endif

  // Word aligned and inside instruction memory; wrapped addresses fall out here.
  assign w_legal = (w_npc[1:0] == 2'b00) && (w_npc >= IM_BASE) && (w_npc <= c_im_last);

  // Sticky fault: any illegal committed next PC is remembered until reset.
  always_ff @(posedge clk) begin
    if (reset)                       r_fault <= 1'b0;
    else if (!bus.stall && !w_legal) r_fault <= 1'b1;
  end

  assign bus.npc   = w_npc;
  assign bus.fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_npc_delay_slot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npc_delay_slot
//  Description : Self-checking bench for npc_delay_slot. Directed scenarios
//                followed by randomized cycles, all checked against a
//                reference model built from pending-target queue and fault bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_delay_slot;

  localparam logic [31:0] c_rst_addr = 32'h0000_3000;
  localparam logic [31:0] c_lo       = 32'h0000_3000;
  localparam logic [31:0] c_hi       = 32'h0000_6FFC;
`ifdef NPC_DELAY_SLOT_EN
  localparam bit c_ds = 1'b1;
`else
  localparam bit c_ds = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  npc_delay_slot_if bus();

  npc_delay_slot #(
    .RESET_ADDR (c_rst_addr),
    .IM_BASE    (c_lo),
    .IM_WORDS   (4096)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: targets waiting to be taken after their delay slot.
  logic [31:0] pend_q[$];
  bit          m_fault = 1'b0;
  logic [31:0] last_npc = 32'h0000_3000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit rst, input bit st, input logic [31:0] p,
                      input logic [2:0] op, input bit eq, input logic [15:0] imm,
                      input logic [25:0] idx, input logic [31:0] rs);
    logic [31:0] p4, tgt, e_npc;
    bit tk, viol, slot;
    @(negedge clk);
    reset       = rst;
    bus.stall   = st;
    bus.pc      = p;
    bus.br_op   = op;
    bus.cmp_eq  = eq;
    bus.imm16   = imm;
    bus.index26 = idx;
    bus.rs_val  = rs;

    p4 = p + 32'd4;
    case (op)
      3'd1, 3'd2: tgt = p4 + (32'($signed(imm)) * 4);
      3'd3, 3'd4: tgt = {p4[31:28], idx, 2'b00};
      3'd5:       tgt = rs;
      default:    tgt = p4;
    endcase
    tk   = (op == 3'd1 && eq) || (op == 3'd2 && !eq) || op == 3'd3 || op == 3'd4 || op == 3'd5;
    slot = pend_q.size() > 0;
    if (rst)             e_npc = c_rst_addr;
    else if (st)         e_npc = p;
    else if (slot)       e_npc = pend_q[0];
    else if (!c_ds && tk) e_npc = tgt;
    else                 e_npc = p4;
    viol = slot && !rst && !st && tk;

    #1;
    check("npc", bus.npc, e_npc);
    check("link_addr", bus.link_addr, c_ds ? p + 32'd8 : p + 32'd4);
    check("in_slot", {31'b0, bus.in_slot}, {31'b0, slot});
    check("slot_violation", {31'b0, bus.slot_violation}, {31'b0, viol});
    check("fault", {31'b0, bus.fault}, {31'b0, m_fault});
    last_npc = e_npc;

    @(posedge clk);
    if (rst) begin
      pend_q.delete();
      m_fault = 1'b0;
    end else if (!st) begin
      if (e_npc[1:0] != 2'b00 || e_npc < c_lo || e_npc > c_hi) m_fault = 1'b1;
      if (slot) void'(pend_q.pop_front());
      else if (c_ds && tk) pend_q.push_back(tgt);
    end
  endtask

  initial begin
    bus.stall = 1'b0; bus.pc = '0; bus.br_op = '0; bus.cmp_eq = 1'b0;
    bus.imm16 = '0; bus.index26 = '0; bus.rs_val = '0;

    // Power-up reset, then sequential fetch.
    step(1, 0, 32'h0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 32'h0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);

    // Taken BEQ backwards, then the delay slot commits the target.
    step(0, 0, 32'h3008, 3'd1, 1, 16'hFFFE, 26'h0, 32'h0);
    step(0, 0, 32'h300C, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    // Untaken BEQ / taken BNE.
    step(0, 0, 32'h3004, 3'd1, 0, 16'h0010, 26'h0, 32'h0);
    step(0, 0, 32'h3008, 3'd2, 0, 16'h0004, 26'h0, 32'h0);
    step(0, 0, 32'h300C, 3'd0, 0, 16'h0, 26'h0, 32'h0);

    // Reset arriving while a target is pending.
    step(0, 0, 32'h3000, 3'd1, 1, 16'h0004, 26'h0, 32'h0);
    step(1, 0, 32'h3010, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 32'h3010, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);

    // JAL, then stall three cycles in the delay slot, then redirect.
    step(0, 0, 32'h3020, 3'd4, 0, 16'h0, 26'h0000C40, 32'h0);
    step(0, 1, 32'h3024, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 1, 32'h3024, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 1, 32'h3024, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3024, 3'd0, 0, 16'h0, 26'h0, 32'h0);

    // J followed by another J in its delay slot.
    step(0, 0, 32'h3100, 3'd3, 0, 16'h0, 26'h0001000, 32'h0);
    step(0, 0, 32'h3104, 3'd3, 0, 16'h0, 26'h0001400, 32'h0);
    step(0, 0, 32'h4000, 3'd0, 0, 16'h0, 26'h0, 32'h0);

    // JR to a misaligned address: fault after commit, sticky until reset.
    step(0, 0, 32'h4000, 3'd5, 0, 16'h0, 26'h0, 32'h3002);
    step(0, 0, 32'h4004, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3004, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3008, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 32'h3008, 3'd0, 0, 16'h0, 26'h0, 32'h0);

    // JR out of range.
    step(0, 0, 32'h3000, 3'd5, 0, 16'h0, 26'h0, 32'h7000);
    step(0, 0, 32'h3004, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3008, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 32'h3008, 3'd0, 0, 16'h0, 26'h0, 32'h0);

    // Range boundaries: last legal word, one past it, and address wrap.
    step(0, 0, 32'h6FF8, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h6FFC, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h2FFC, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'hFFFF_FFFC, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    // A stall on an illegal PC must not set fault.
    step(1, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 1, 32'h7000, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 0, 32'h3000, 3'd0, 0, 16'h0, 26'h0, 32'h0);

    // Randomized traffic; pc usually follows the previous next PC.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p, rs;
      bit r, s;
      r = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 3) != 0) p = last_npc;
      else if ($urandom_range(0, 7) == 0) p = $urandom;
      else p = c_lo + {18'b0, 12'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) rs = $urandom;
      else rs = c_lo + {18'b0, 12'($urandom), 2'b00};
      step(r, s, p, 3'($urandom), 1'($urandom), 16'($urandom), 26'($urandom), rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
